// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/memory_stage_lsu_load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign/zero extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    result = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_BU ? {24'b0, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/memory_stage_lsu.sv
// memory_stage_lsu: RV32I MEM-stage load/store unit with req/ack bus FSM and M->W register.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of forcing alignment.
module memory_stage_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        LoadM,
  input  logic        StoreM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] InstrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] InstrW,
  output logic        MisalignW
);
  state_t      state;
  logic [2:0]  f3, f3_q;
  logic [1:0]  off, off_q;
  logic [3:0]  be;
  logic [31:0] wdata, ld_data;
  logic        access, trap, ack_done;
  assign f3 = InstrM[14:12];
  assign access = LoadM | StoreM;
  // f3[1] marks word width (incl. funct3 11x); f3[0] marks half width
  assign off = f3[1] ? 2'b00 : f3[0] ? {ALU_ResultM[1], 1'b0} : ALU_ResultM[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = access && (f3[1] ? |ALU_ResultM[1:0] : f3[0] & ALU_ResultM[0]);
`else
  assign trap = 1'b0;
`endif
  assign be = !StoreM ? 4'hF : f3[1] ? 4'hF : f3[0] ? 4'b0011 << off : 4'b0001 << off;
  assign wdata = f3[1] ? WriteDataM : f3[0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
  assign ack_done = (state == BUSY) && dmem_ack;
  assign dmem_req = (state == BUSY);
  assign StallM = (state == IDLE) ? (access && !trap) : !dmem_ack;
  load_extend u_ext (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= '0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      InstrW      <= '0;
      MisalignW   <= 1'b0;
    end else begin
      if (state == IDLE && access && !trap) begin
        state      <= BUSY;
        dmem_we    <= StoreM;
        dmem_addr  <= {ALU_ResultM[31:2], 2'b00};
        dmem_be    <= be;
        dmem_wdata <= wdata;
        off_q      <= off;
        f3_q       <= f3;
      end else if (ack_done) begin
        state <= IDLE;
      end
      if (StallM) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= '0;
        MisalignW  <= 1'b0;
      end else begin
        RegWriteW   <= RegWriteM && !trap;
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        ReadDataW   <= (ack_done && !dmem_we) ? ld_data : 32'h0;
        InstrW      <= InstrM;
        MisalignW   <= trap;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage_lsu.sv
// tb_memory_stage_lsu: directed self-checking bench for memory_stage_lsu.
module tb_memory_stage_lsu;
  logic        clk, rst;
  logic        RegWriteM, LoadM, StoreM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM, InstrM;
  logic        dmem_req, dmem_we, dmem_ack, StallM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, InstrW;
  int n_chk = 0;
  int n_fail = 0;
  memory_stage_lsu dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .LoadM(LoadM), .StoreM(StoreM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .InstrM(InstrM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .InstrW(InstrW), .MisalignW(MisalignW)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_m;
    RegWriteM = 0; LoadM = 0; StoreM = 0; ResultSrcM = 0; RD_M = 0;
    PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0; InstrM = 0;
  endtask
  task automatic set_mem(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    RegWriteM = ld; LoadM = ld; StoreM = st; ResultSrcM = ld ? 2'd1 : 2'd0; RD_M = 5'd7;
    PCPlus4M = 32'h404; ALU_ResultM = addr; WriteDataM = wd;
    InstrM = {17'b0, f3, 5'd7, st ? 7'h23 : 7'h03};
  endtask
  task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int k, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rd);
    int stalls;
    set_mem(ld, st, f3, addr, wd);
    #1;
    stalls = StallM ? 1 : 0;
    tick;
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'(st));
    chk({tag, "_be"}, 32'(dmem_be), 32'(e_be));
    if (st) chk({tag, "_wdata"}, dmem_wdata, e_wdata);
    for (int i = 1; i <= k; i++) begin
      dmem_ack = (i == k);
      dmem_rdata = (i == k) ? rdata : 32'hDEADBEEF;
      #1;
      if (StallM) stalls++;
      chk({tag, "_req_hold"}, 32'(dmem_req), 32'd1);
      chk({tag, "_addr"}, dmem_addr, e_addr);
      chk({tag, "_bubble"}, 32'(RegWriteW), 32'd0);
      tick;
    end
    dmem_ack = 0;
    clear_m;
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(k));
    chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    chk({tag, "_rdata"}, ReadDataW, e_rd);
    chk({tag, "_regwrite"}, 32'(RegWriteW), 32'(ld));
    chk({tag, "_aluw"}, ALU_ResultW, addr);
    chk({tag, "_misalign"}, 32'(MisalignW), 32'd0);
  endtask
  initial begin
    rst = 1; dmem_ack = 0; dmem_rdata = 0;
    clear_m;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_aluw", ALU_ResultW, 32'd0);
    chk("rst_rdata", ReadDataW, 32'd0);
    chk("rst_misalign", 32'(MisalignW), 32'd0);
    RegWriteM = 1; ALU_ResultM = 32'h1234; RD_M = 5'd5; PCPlus4M = 32'h104;
    InstrM = 32'h002082B3;
    #1 chk("add_stall", 32'(StallM), 32'd0);
    tick;
    chk("add_aluw", ALU_ResultW, 32'h1234);
    chk("add_regwrite", 32'(RegWriteW), 32'd1);
    chk("add_rd", 32'(RD_W), 32'd5);
    chk("add_pc4", PCPlus4W, 32'h104);
    chk("add_req", 32'(dmem_req), 32'd0);
    clear_m;
    mem_op("sb", 0, 1, 3'b000, 32'h103, 32'hAB, 32'h0, 1, 32'h100, 4'b1000, 32'hABABABAB, 32'h0);
    mem_op("sh", 0, 1, 3'b001, 32'h102, 32'h5678, 32'h0, 2, 32'h100, 4'b1100, 32'h56785678, 32'h0);
    mem_op("sw", 0, 1, 3'b010, 32'h200, 32'hCAFEBABE, 32'h0, 1, 32'h200, 4'b1111, 32'hCAFEBABE, 32'h0);
    mem_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 3, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80);
    mem_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 3, 32'h100, 4'hF, 32'h0, 32'h00000080);
    mem_op("lh", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2, 32'h100, 4'hF, 32'h0, 32'hFFFF8001);
    mem_op("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 32'h80011234, 1, 32'h100, 4'hF, 32'h0, 32'h00001234);
`ifdef LSU_MISALIGN_TRAP_EN
    set_mem(1, 0, 3'b010, 32'h102, 32'h0);
    #1 chk("mis_stall", 32'(StallM), 32'd0);
    tick;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_flag", 32'(MisalignW), 32'd1);
    chk("mis_regwrite", 32'(RegWriteW), 32'd0);
    chk("mis_rdata", ReadDataW, 32'd0);
    clear_m;
`else
    mem_op("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1, 32'h100, 4'hF, 32'h0, 32'h11223344);
`endif
    set_mem(1, 0, 3'b010, 32'h300, 32'h0);
    tick;
    tick;
    chk("rb_req_busy", 32'(dmem_req), 32'd1);
    rst = 1;
    clear_m;
    tick;
    rst = 0;
    #1;
    chk("rb_req", 32'(dmem_req), 32'd0);
    chk("rb_stall", 32'(StallM), 32'd0);
    chk("rb_regwrite", 32'(RegWriteW), 32'd0);
    chk("rb_aluw", ALU_ResultW, 32'd0);
    chk("rb_rdata", ReadDataW, 32'd0);
    chk("rb_instr", InstrW, 32'd0);
    chk("rb_pc4", PCPlus4W, 32'd0);
    dmem_ack = 1; dmem_rdata = 32'h55AA55AA;
    #1 chk("stray_stall", 32'(StallM), 32'd0);
    tick;
    dmem_ack = 0;
    chk("stray_req", 32'(dmem_req), 32'd0);
    chk("stray_rdata", ReadDataW, 32'd0);
    chk("stray_regwrite", 32'(RegWriteW), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
